// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat register commands into AXI4-Lite write/read
// transactions, one outstanding at a time, with a watchdog that aborts hung transfers.
module axi_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d, cnt_inc;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                      arvalid_q, arvalid_d, rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      aw_pend, w_pend, timeout_hit, abort;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    aw_pend       = awvalid_q && !m_axi_awready;
    w_pend        = wvalid_q && !m_axi_wready;
    cnt_inc       = cnt_q + 16'd1;
    timeout_hit   = (cnt_inc == 16'(TIMEOUT));
    abort         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        // bready is already up here, but a B beat before both AW and W finish is ignored.
        cnt_d     = cnt_inc;
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) state_d = S_WRESP;
        abort     = timeout_hit;
      end
      S_WRESP: begin
        cnt_d = cnt_inc;
        if (m_axi_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else begin
          abort = timeout_hit;
        end
      end
      S_RADDR: begin
        cnt_d = cnt_inc;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
        abort = timeout_hit;
      end
      S_RDATA: begin
        cnt_d = cnt_inc;
        if (m_axi_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else begin
          abort = timeout_hit;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A real response on the watchdog's final cycle is handled above and never sets abort.
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b11;
      rsp_timeout_d = 1'b1;
      state_d       = S_RESP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: scripted slave with random delays, expectations derived
// from handshake-edge arithmetic (response edge vs. watchdog limit) per transaction.
module tb_axi_lite_cmd_master;

  localparam int T = 8;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int errors = 0;

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  // Called on a falling edge with the DUT idle. Edge j counts rising edges from the
  // acceptance edge (j=0). da/dw: cycles before awready/wready (arready for reads);
  // dd: extra cycles before bvalid (after AW+W) or rvalid (after AR).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int da, input int dw, input int dd,
                         input int hold, input logic [31:0] sl_rdata, input logic [1:0] sl_resp);
    int r, rexp;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    logic        e_to;
    logic [6:0]  e_ctl;
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    rsp_ready = (hold == 0);
    m_axi_rdata = sl_rdata; m_axi_rresp = sl_resp; m_axi_bresp = sl_resp;
    r    = wr ? (1 + ((da > dw) ? da : dw) + 1 + dd) : (2 + da + dd);
    rexp = (r <= T) ? r : T;
    if (r > T)  begin e_rdata = 32'd0;    e_resp = 2'b11;   e_to = 1'b1; end
    else if (wr) begin e_rdata = 32'd0;    e_resp = sl_resp; e_to = 1'b0; end
    else        begin e_rdata = sl_rdata; e_resp = sl_resp; e_to = 1'b0; end
    for (int j = 0; j <= rexp + hold + 1; j++) begin
      @(posedge axi_aclk);
      @(negedge axi_aclk);
      e_ctl = {wr && j < 1 + da && j < T,           // awvalid
               wr && j < 1 + dw && j < T,           // wvalid
               wr && j < rexp,                      // bready
               !wr && j < 1 + da && j < T,          // arvalid
               !wr && j >= 1 + da && j < rexp,      // rready
               j >= rexp && j <= rexp + hold,       // rsp_valid
               j > rexp + hold};                    // cmd_ready
      check($sformatf("ctl[j=%0d]", j),
            {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
             m_axi_rready, rsp_valid, cmd_ready}, {57'd0, e_ctl});
      if (j == 0 && wr)
        check("aw_w_payload", {m_axi_awaddr, m_axi_wdata}, {addr, wdata});
      if (j == 0 && wr)
        check("wstrb_prot", {57'd0, m_axi_wstrb, m_axi_awprot}, {57'd0, wstrb, 3'b000});
      if (j == 0 && !wr)
        check("araddr_prot", {29'd0, m_axi_arprot, m_axi_araddr}, {29'd0, 3'b000, addr});
      if (j >= rexp && j <= rexp + hold)
        check($sformatf("rsp[j=%0d]", j), {29'd0, rsp_rdata, rsp_resp, rsp_timeout},
              {29'd0, e_rdata, e_resp, e_to});
      m_axi_awready = wr && j == da;
      m_axi_wready  = wr && j == dw;
      m_axi_bvalid  = wr && j == r - 1;
      m_axi_arready = !wr && j == da;
      m_axi_rvalid  = !wr && j == r - 1;
      if (j == rexp + hold) rsp_ready = 1'b1;
      // Keep a command queued while the response is pending; it must not be taken.
      cmd_valid = (hold > 0) && j >= rexp && j <= rexp + hold;
    end
    slave_idle();
  endtask

  initial begin
    bit wr;
    int da, dw, dd, hold;
    axi_aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; m_axi_bresp = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    slave_idle();
    #12;
    check("reset_ctl", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                        m_axi_rready, rsp_valid, cmd_ready}, 64'd1);
    check("reset_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
    check("reset_data", {m_axi_wdata, rsp_rdata}, 64'd0);
    check("reset_misc", {57'd0, m_axi_wstrb, rsp_resp, rsp_timeout}, 64'd0);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);

    // Best-case write, then wready lagging awready by 3 cycles.
    run_txn(1'b1, 32'h4, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 32'h0, 2'b00);
    run_txn(1'b1, 32'h10, 32'h1234_5678, 4'h3, 0, 3, 1, 0, 32'h0, 2'b01);
    run_txn(1'b1, 32'h14, 32'hCAFE_F00D, 4'hC, 2, 0, 0, 0, 32'h0, 2'b10);
    // Reads: normal with SLVERR, arready never comes, then recovery.
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b10);
    run_txn(1'b0, 32'hC, 32'h0, 4'h0, 100, 0, 0, 0, 32'h5555_AAAA, 2'b00);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 2, 0, 32'h0BAD_CAFE, 2'b00);
    // Response held off for 5 cycles with a command queued behind it.
    run_txn(1'b1, 32'h24, 32'hFFFF_0000, 4'hF, 1, 1, 1, 5, 32'h0, 2'b11);
    // Response exactly on the watchdog edge wins; one cycle later it loses.
    run_txn(1'b1, 32'h28, 32'h0000_0001, 4'h1, 0, 0, 6, 0, 32'h0, 2'b01);
    run_txn(1'b0, 32'h2C, 32'h0, 4'h0, 2, 0, 4, 0, 32'h7777_8888, 2'b01);
    run_txn(1'b1, 32'h30, 32'h0000_0002, 4'h2, 0, 0, 7, 0, 32'h0, 2'b00);
    run_txn(1'b1, 32'h34, 32'h0000_0003, 4'h4, 3, 20, 0, 2, 32'h0, 2'b00);

    // Asynchronous reset in the middle of a write address phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h99; cmd_wstrb = 4'hF;
    rsp_ready = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    check("pre_rst_aw_w", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
    @(posedge axi_aclk);
    #2 axi_aresetn = 1'b0;
    #1 check("async_rst", {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, rsp_valid, cmd_ready}, 64'd1);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge axi_aclk);
      check("post_rst_quiet", {61'd0, m_axi_awvalid, rsp_valid, cmd_ready}, 64'd1);
    end
    run_txn(1'b1, 32'h44, 32'hABCD_0123, 4'hF, 0, 1, 0, 0, 32'h0, 2'b00);

    // Randomized traffic, including occasional hangs.
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      da   = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 4));
      dw   = int'($urandom_range(0, 4));
      dd   = int'($urandom_range(0, 4));
      hold = int'($urandom_range(0, 3));
      run_txn(wr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), da, dw, dd, hold,
              $urandom, 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
